// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
package nibble_serial_add_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Nibble index width; kept at least 1 bit so NIBBLES=2 still gets a real counter.
  function automatic int unsigned idx_width(input int unsigned nibbles);
    return (nibbles <= 2) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Request/response bundle between a requester (master) and the controller (slave).
interface nibble_serial_add_ctrl_if #(
  parameter int unsigned NIBBLES = 4
);
  import nibble_serial_add_pkg::*;

  localparam int unsigned W = NIBBLE_W * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;
  logic         op_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  modport master (
    output in_valid, op_a, op_b, op_sub, op_cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, op_a, op_b, op_sub, op_cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );

endinterface

// File: rtl/nibble_serial_add_ctrl_add4.sv
// Combinational 4-bit adder slice time-shared by the serial controller.
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign s      = w_full[3:0];
  assign cout   = w_full[4];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide add/subtract performed LSB nibble first through a single 4-bit adder,
// with valid/ready handshakes on both the request and the result side.
module nibble_serial_add_ctrl
  import nibble_serial_add_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  nibble_serial_add_ctrl_if.slave bus
);

  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_carry;
  logic [W-1:0]          r_a;
  logic [W-1:0]          r_b;
  logic [W-1:0]          r_sum;
  logic                  r_cout;
  logic                  r_ovf;

  logic [NIBBLE_W-1:0]   w_a_nib;
  logic [NIBBLE_W-1:0]   w_b_nib;
  logic [NIBBLE_W-1:0]   w_s;
  logic                  w_c;

  assign w_a_nib = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
  assign w_b_nib = r_b[r_idx*NIBBLE_W +: NIBBLE_W];

  nibble_add4 u_add4 (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.op_a;
            // Subtract is A + ~B + 1, so B is inverted once at accept time.
            r_b     <= bus.op_sub ? ~bus.op_b : bus.op_b;
            r_carry <= bus.op_sub | bus.op_cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sum[r_idx*NIBBLE_W +: NIBBLE_W] <= w_s;
          r_carry <= w_c;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_c;
            r_ovf   <= (r_a[W-1] == r_b[W-1]) && (w_s[NIBBLE_W-1] != r_a[W-1]);
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl with a result scoreboard queue.
module tb_nibble_serial_add_ctrl;
  import nibble_serial_add_pkg::*;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = NIBBLE_W * NIBBLES;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nibble_serial_add_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin);
    logic [W-1:0] bb;
    logic [W:0]   full;
    res_t         r;
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub | cin)};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return r;
  endfunction

  // Waits for in_ready, presents one request for exactly one accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin, output bit ok);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = bus.in_ready;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_sub   = sub;
    bus.op_cin   = cin;
    bus.in_valid = ok;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Counts negedges from the accept until out_valid; flags in_ready high / busy low meanwhile.
  task automatic wait_done(output int cycles, output bit bad);
    cycles = 0;
    bad    = bus.in_ready || !bus.busy;
    while (!bus.out_valid && cycles < 50) begin
      @(negedge clk);
      cycles++;
      if (bus.in_ready || !bus.busy) bad = 1'b1;
    end
  endtask

  task automatic take_result(output res_t r);
    r = {bus.sum, bus.cout, bus.ovf};
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
    checks++;
    if (bus.sum !== '0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_result: sum=%h cout=%b ovf=%b, required 0000 0 0",
               bus.sum, bus.cout, bus.ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_latency();
    bit   ok, bad;
    int   cyc;
    res_t got, exp;
    start_op(16'h00FF, 16'h0001, 1'b0, 1'b0, ok);
    exp_q.push_back('{sum: 16'h0100, cout: 1'b0, ovf: 1'b0});
    wait_done(cyc, bad);
    checks++;
    if (cyc != NIBBLES || !ok) begin
      errors++;
      $display("FAIL latency: out_valid after %0d cycles (accepted=%0b), required %0d",
               cyc, ok, NIBBLES);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL ready_in_run: in_ready high or busy low during RUN, required in_ready=0 busy=1");
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_done: in_ready=%b, required 0", bus.in_ready);
    end
    take_result(got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL add_00ff_0001: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
               got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf);
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_handshake: in_ready=%b out_valid=%b, required 1 0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_arith();
    logic [W-1:0] va[4] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [W-1:0] vb[4] = '{16'h0001, 16'h0000, 16'h0007, 16'h0001};
    logic         vs[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic         vc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    res_t         ve[4] = '{'{16'h0000, 1'b1, 1'b0}, '{16'h8000, 1'b0, 1'b1},
                            '{16'hFFFE, 1'b0, 1'b0}, '{16'h7FFF, 1'b1, 1'b1}};
    for (int i = 0; i < 4; i++) begin
      bit   ok, bad;
      int   cyc;
      res_t got, exp;
      start_op(va[i], vb[i], vs[i], vc[i], ok);
      exp_q.push_back(ve[i]);
      wait_done(cyc, bad);
      exp = exp_q.pop_front();
      checks++;
      if (!bus.out_valid) begin
        errors++;
        $display("FAIL arith_%0d_timeout: out_valid=%b after %0d cycles, required 1",
                 i, bus.out_valid, cyc);
      end else begin
        take_result(got);
        if (got !== exp) begin
          errors++;
          $display("FAIL arith_%0d: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                   i, got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit   ok, bad;
    int   cyc;
    res_t got, exp;
    start_op(16'h1357, 16'h2468, 1'b0, 1'b1, ok);
    exp_q.push_back(model(16'h1357, 16'h2468, 1'b0, 1'b1));
    wait_done(cyc, bad);
    exp = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.op_a     = 16'($urandom);
      @(negedge clk);
      got = {bus.sum, bus.cout, bus.ovf};
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || got !== exp) begin
        errors++;
        $display("FAIL backpressure_%0d: out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b, required 1 0 sum=%h cout=%b ovf=%b",
                 i, bus.out_valid, bus.in_ready, got.sum, got.cout, got.ovf,
                 exp.sum, exp.cout, exp.ovf);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_reset_mid_run();
    bit   ok, bad, saw_valid;
    int   cyc;
    res_t got, exp;
    saw_valid = 1'b0;
    start_op(16'h1234, 16'h1111, 1'b0, 1'b0, ok);
    repeat (2) begin
      @(negedge clk);
      if (bus.out_valid) saw_valid = 1'b1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.sum !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: in_ready=%b busy=%b sum=%h, required 1 0 0000",
               bus.in_ready, bus.busy, bus.sum);
    end
    rst_n = 1'b1;
    repeat (NIBBLES + 2) begin
      @(negedge clk);
      if (bus.out_valid) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid) begin
      errors++;
      $display("FAIL dropped_op: out_valid=1 seen for aborted operation, required 0");
    end
    start_op(16'h0001, 16'h0001, 1'b0, 1'b0, ok);
    exp_q.push_back('{sum: 16'h0002, cout: 1'b0, ovf: 1'b0});
    wait_done(cyc, bad);
    take_result(got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL after_reset_add: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
               got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ta[3] = '{16'h1111, 16'h0010, 16'hFFFF};
    logic [W-1:0] tb[3] = '{16'h2222, 16'h0020, 16'hFFFF};
    logic         ts[3] = '{1'b0, 1'b1, 1'b0};
    logic         tc[3] = '{1'b0, 1'b0, 1'b1};
    int acc = 0, got_n = 0, cyc = 0, last_acc = -1;
    res_t got, exp;
    bus.op_a      = ta[0];
    bus.op_b      = tb[0];
    bus.op_sub    = ts[0];
    bus.op_cin    = tc[0];
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    while (got_n < 3 && cyc < 100) begin
      if (bus.out_valid) begin
        got = {bus.sum, bus.cout, bus.ovf};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: unexpected result sum=%h, required no result", got.sum);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL b2b_result_%0d: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                     got_n, got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf);
          end
        end
        got_n++;
      end
      if (bus.in_ready && bus.in_valid) begin
        exp_q.push_back(model(ta[acc], tb[acc], ts[acc], tc[acc]));
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != NIBBLES + 2) begin
            errors++;
            $display("FAIL b2b_spacing_%0d: %0d cycles between accepts, required %0d",
                     acc, cyc - last_acc, NIBBLES + 2);
          end
        end
        last_acc = cyc;
        acc++;
      end
      @(negedge clk);
      cyc++;
      if (acc < 3) begin
        bus.op_a   = ta[acc];
        bus.op_b   = tb[acc];
        bus.op_sub = ts[acc];
        bus.op_cin = tc[acc];
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (got_n != 3 || acc != 3) begin
      errors++;
      $display("FAIL b2b_count: %0d accepts and %0d results, required 3 and 3", acc, got_n);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_sub    = 1'b0;
    bus.op_cin    = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_add_latency();
    test_arith();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Controller that time-shares one 4-bit nibble adder to perform wide (4*NIBBLES-bit) add/subtract operations nibble-serially, LSB nibble first, with the carry chained through a register.
It takes one operation at a time over a valid/ready input handshake and returns the result over a valid/ready output handshake.
It is the sequencing layer above the 4-bit adder datapath, so wider arithmetic runs without widening the adder.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 2..8.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  reset, synchronous, active-low.
in_valid  input  1  operation request valid.
in_ready  output  1  controller can accept an operation (high only in IDLE).
op_a  input  W  operand A.
op_b  input  W  operand B.
op_sub  input  1  1 = A - B (B inverted, carry-in forced 1); 0 = A + B + op_cin.
op_cin  input  1  carry-in for add; ignored when op_sub=1.
out_valid  output  1  result valid (high only in DONE).
out_ready  input  1  consumer accepts result.
sum  output  W  result.
cout  output  1  carry out of MSB nibble (for subtract, 1 = no borrow).
ovf  output  1  signed two's-complement overflow.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low at a rising edge): state=IDLE; nibble index=0; carry reg=0; sum=0; cout=0; ovf=0; operand regs=0. Outputs after reset: in_ready=1, out_valid=0, busy=0. Reset has priority over every other event, including mid-RUN and mid-DONE; any in-flight operation is dropped with no output.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On an edge with in_valid=1:
  - latch op_a;
  - latch op_b, or ~op_b when op_sub=1;
  - carry reg <= op_sub ? 1 : op_cin;
  - index <= 0; clear sum; go to RUN.
  - In the same edge, nothing else changes.
- RUN: in_ready=0. Each cycle:
  - nibble adder computes {c,s} = A[idx] + B'[idx] + carry;
  - sum nibble idx <= s; carry <= c; idx <= idx+1.
  - When idx == NIBBLES-1: cout <= c; ovf <= (A_msb == B'_msb) && (s_msb != A_msb); go to DONE.
- DONE: out_valid=1. sum, cout and ovf are held stable until the handshake. On an edge with out_ready=1, go to IDLE. There is no bypass: the next operation cannot be accepted on the same edge as the result handshake.
- Latency: accept at edge k; out_valid is first high after edge k+NIBBLES. Back-to-back throughput is one operation per NIBBLES+2 cycles when out_ready is held high.
- in_valid is ignored in RUN and DONE. op_a, op_b, op_sub and op_cin are sampled only at the accept edge; later changes have no effect.
- out_ready is ignored outside DONE.
- sum keeps its last value in IDLE until the next accept clears it.
- Width rules: all arithmetic is modulo 2^W. The index counter is clog2(NIBBLES) bits and never wraps in normal operation, because the FSM leaves RUN at NIBBLES-1.

Decomposition:
- Package nibble_serial_add_pkg:
  - NIBBLE_W = 4;
  - state enum {ST_IDLE, ST_RUN, ST_DONE};
  - helper function to compute index width from NIBBLES.
- Sub-module nibble_add4: purely combinational 4-bit adder with ports a[3:0], b[3:0], cin, s[3:0], cout. The controller instantiates exactly one.

Test Plan:
- NIBBLES=4; add 0x00FF + 0x0001, cin=0 -> sum=0x0100, cout=0, ovf=0; out_valid rises exactly 4 cycles after accept; in_ready low throughout RUN and DONE.
- Add 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Add 0x7FFF + 0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
- Subtract 0x0005 - 0x0007 -> sum=0xFFFE, cout=0, ovf=0. Subtract 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and changing op_a -> sum/cout/ovf stable, no new accept. Then out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-RUN: start 0x1234 + 0x1111, assert rst_n=0 after 2 RUN cycles -> next edge gives IDLE, sum=0, out_valid never asserted. A following 0x0001 + 0x0001 -> sum=0x0002.
- Back-to-back: out_ready tied 1 and in_valid tied 1 with three operations -> accepts spaced NIBBLES+2 = 6 cycles apart, each result correct.
